// File: rtl/mtc_builder_sync.sv
// -----------------------------------------------------------------------------
// mtc_builder_sync
// Pairs slc pipeline candidates with pt-calculation results and emits MTC
// packets. Each of the N_SL slots owns one slc input and one mtc output and
// runs an IDLE -> WAIT -> EMIT cycle: an slc word is latched, the slot waits
// for a valid ptcalc word on the thread named by the slc process-channel
// field, and then emits {valid, pt_ok, ptcalc word, slc word} for one cycle.
// A slot that waits TIMEOUT cycles emits with pt_ok=0 and a zero payload.
//
// Ports
//   clock        : single clock
//   rst          : synchronous, active-high reset
//   slc[i]       : slc candidate for slot i, MSB = valid
//   ptcalc[t]    : pt result for thread t, MSB = valid
//   mtc[i]       : registered packet of slot i, all-zero when not emitting
//   drop_cnt     : saturating count of slc words discarded by busy slots
//   timeout_cnt  : saturating count of slots that gave up waiting
//   busy[i]      : slot i is not IDLE
// -----------------------------------------------------------------------------
module mtc_builder_sync #(
  parameter int PTCALC_WIDTH = 20,  // ptcalc word width, MSB = valid
  parameter int SLC_WIDTH    = 24,  // slc word width, MSB = valid
  parameter int PCH_MSB      = 5,   // process-channel field in the slc word
  parameter int PCH_LSB      = 4,
  parameter int N_THREADS    = 3,
  parameter int N_SL         = 3,
  parameter int TIMEOUT      = 64,  // 1..1023
  parameter int CNT_WIDTH    = 16
) (
  input  logic                                 clock,
  input  logic                                 rst,
  input  logic [SLC_WIDTH-1:0]                 slc         [N_SL],
  input  logic [PTCALC_WIDTH-1:0]              ptcalc      [N_THREADS],
  output logic [SLC_WIDTH+PTCALC_WIDTH+1:0]    mtc         [N_SL],
  output logic [CNT_WIDTH-1:0]                 drop_cnt,
  output logic [CNT_WIDTH-1:0]                 timeout_cnt,
  output logic [N_SL-1:0]                      busy
);

  localparam int         PCH_W    = PCH_MSB - PCH_LSB + 1;
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t                  state_r    [N_SL];
  state_t                  state_s    [N_SL];
  logic [PCH_W-1:0]        thread_r   [N_SL];
  logic [PCH_W-1:0]        thread_s   [N_SL];
  logic [9:0]              wait_cnt_r [N_SL];
  logic [9:0]              wait_cnt_s [N_SL];
  logic [SLC_WIDTH-1:0]    slc_r      [N_SL];
  logic [SLC_WIDTH-1:0]    slc_s      [N_SL];
  logic [PTCALC_WIDTH-1:0] pt_r       [N_SL];
  logic [PTCALC_WIDTH-1:0] pt_s       [N_SL];
  logic [N_SL-1:0]         pt_ok_r;
  logic [N_SL-1:0]         pt_ok_s;
  logic [N_SL-1:0]         drop_s;
  logic [N_SL-1:0]         tmo_s;

  // Add one per asserted event bit, holding at all-ones once reached.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic [N_SL-1:0] ev);
    logic [CNT_WIDTH-1:0] acc;
    acc = cnt;
    for (int k = 0; k < N_SL; k++) begin
      if (ev[k] && (acc != {CNT_WIDTH{1'b1}})) begin
        acc = acc + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  // Per-slot next-state logic, including the lowest-index-wins thread arbitration.
  always_comb begin
    logic [N_THREADS-1:0]    claimed;
    logic                    known;
    logic                    hit;
    logic [PTCALC_WIDTH-1:0] sel_pt;
    claimed = '0;
    drop_s  = '0;
    tmo_s   = '0;
    pt_ok_s = pt_ok_r;
    for (int i = 0; i < N_SL; i++) begin
      state_s[i]    = state_r[i];
      thread_s[i]   = thread_r[i];
      wait_cnt_s[i] = wait_cnt_r[i];
      slc_s[i]      = slc_r[i];
      pt_s[i]       = pt_r[i];
      known         = 1'b0;
      hit           = 1'b0;
      sel_pt        = '0;
      // A process channel outside 0..N_THREADS-1 has no thread to wait on.
      for (int t = 0; t < N_THREADS; t++) begin
        known = known | (slc[i][PCH_MSB:PCH_LSB] == PCH_W'(t));
      end
      // Slots are scanned in index order, so a thread already claimed this
      // cycle is invisible to higher-index slots.
      for (int t = 0; t < N_THREADS; t++) begin
        if ((state_r[i] == WAIT) && !hit && !claimed[t] &&
            (thread_r[i] == PCH_W'(t)) && ptcalc[t][PTCALC_WIDTH-1]) begin
          hit        = 1'b1;
          claimed[t] = 1'b1;
          sel_pt     = ptcalc[t];
        end else begin
          hit = hit;
        end
      end
      case (state_r[i])
        IDLE: begin
          if (slc[i][SLC_WIDTH-1]) begin
            slc_s[i]      = slc[i];
            thread_s[i]   = slc[i][PCH_MSB:PCH_LSB];
            wait_cnt_s[i] = 10'd0;
            pt_s[i]       = '0;
            pt_ok_s[i]    = 1'b0;
            state_s[i]    = known ? WAIT : EMIT;
          end else begin
            state_s[i] = IDLE;
          end
        end
        WAIT: begin
          wait_cnt_s[i] = wait_cnt_r[i] + 10'd1;
          drop_s[i]     = slc[i][SLC_WIDTH-1];
          if (hit) begin
            pt_s[i]    = sel_pt;
            pt_ok_s[i] = 1'b1;
            state_s[i] = EMIT;
          end else if (wait_cnt_r[i] == TMO_LAST) begin
            pt_s[i]    = '0;
            pt_ok_s[i] = 1'b0;
            tmo_s[i]   = 1'b1;
            state_s[i] = EMIT;
          end else begin
            state_s[i] = WAIT;
          end
        end
        EMIT: begin
          drop_s[i]  = slc[i][SLC_WIDTH-1];
          state_s[i] = IDLE;
        end
        default: begin
          state_s[i] = IDLE;
        end
      endcase
    end
  end

  // Slot state and latched entry registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < N_SL; i++) begin
        state_r[i]    <= IDLE;
        thread_r[i]   <= '0;
        wait_cnt_r[i] <= 10'd0;
        slc_r[i]      <= '0;
        pt_r[i]       <= '0;
      end
      pt_ok_r <= '0;
    end else begin
      for (int i = 0; i < N_SL; i++) begin
        state_r[i]    <= state_s[i];
        thread_r[i]   <= thread_s[i];
        wait_cnt_r[i] <= wait_cnt_s[i];
        slc_r[i]      <= slc_s[i];
        pt_r[i]       <= pt_s[i];
      end
      pt_ok_r <= pt_ok_s;
    end
  end

  // Registered outputs: packets leave on the EMIT cycle, busy tracks next state.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int i = 0; i < N_SL; i++) begin
        mtc[i] <= '0;
      end
      busy        <= '0;
      drop_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      for (int i = 0; i < N_SL; i++) begin
        mtc[i]  <= (state_r[i] == EMIT) ? {1'b1, pt_ok_r[i], pt_r[i], slc_r[i]} : '0;
        busy[i] <= (state_s[i] != IDLE);
      end
      drop_cnt    <= sat_add(drop_cnt, drop_s);
      timeout_cnt <= sat_add(timeout_cnt, tmo_s);
    end
  end

endmodule

// File: tb/tb_mtc_builder_sync.sv
// Self-checking bench for mtc_builder_sync: directed scenarios plus a
// randomized run checked against a deadline-based transaction model.
module tb_mtc_builder_sync;

  localparam int PT_W  = 20;
  localparam int SLC_W = 24;
  localparam int MTC_W = SLC_W + PT_W + 2;
  localparam int TMO   = 64;

  logic             clock = 1'b0;
  logic             rst   = 1'b1;
  logic [SLC_W-1:0] slc_a  [3];
  logic [PT_W-1:0]  pt_a   [3];
  logic [MTC_W-1:0] mtc_a  [3];
  logic [15:0]      drop_a, tmo_a;
  logic [2:0]       busy_a;
  logic [SLC_W-1:0] slc_b  [3];
  logic [PT_W-1:0]  pt_b   [3];
  logic [MTC_W-1:0] mtc_b  [3];
  logic [3:0]       drop_b, tmo_b;
  logic [2:0]       busy_b;

  int checks = 0;
  int errors = 0;

  // transaction model for DUT a
  bit               m_act [3];
  bit               m_dec [3];
  int               m_start [3];
  int               m_thr [3];
  logic [SLC_W-1:0] m_word [3];
  logic [PT_W-1:0]  m_pt [3];
  bit               m_ok [3];
  logic [MTC_W-1:0] m_exp [3];
  int               m_drop, m_tmo, now;

  always #5 clock = ~clock;

  mtc_builder_sync #(.PTCALC_WIDTH(PT_W), .SLC_WIDTH(SLC_W), .PCH_MSB(5), .PCH_LSB(4),
                     .N_THREADS(3), .N_SL(3), .TIMEOUT(TMO), .CNT_WIDTH(16)) dut_a (
    .clock(clock), .rst(rst), .slc(slc_a), .ptcalc(pt_a), .mtc(mtc_a),
    .drop_cnt(drop_a), .timeout_cnt(tmo_a), .busy(busy_a));

  mtc_builder_sync #(.PTCALC_WIDTH(PT_W), .SLC_WIDTH(SLC_W), .PCH_MSB(5), .PCH_LSB(4),
                     .N_THREADS(3), .N_SL(3), .TIMEOUT(TMO), .CNT_WIDTH(4)) dut_b (
    .clock(clock), .rst(rst), .slc(slc_b), .ptcalc(pt_b), .mtc(mtc_b),
    .drop_cnt(drop_b), .timeout_cnt(tmo_b), .busy(busy_b));

  function automatic logic [SLC_W-1:0] mk_slc(input int pch);
    logic [SLC_W-1:0] w;
    w = SLC_W'($urandom);
    w[SLC_W-1] = 1'b1;
    w[5:4] = 2'(pch);
    return w;
  endfunction

  function automatic logic [PT_W-1:0] mk_pt();
    logic [PT_W-1:0] w;
    w = PT_W'($urandom);
    w[PT_W-1] = 1'b1;
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0; m_dec[i] = 1'b0; m_exp[i] = '0;
    end
    m_drop = 0; m_tmo = 0; now = 0;
  endtask

  // One clock edge of the model: a decided entry appears on mtc one edge
  // after its decision; a waiting entry decides on a free ptcalc word or
  // once TIMEOUT edges have passed since it was latched.
  task automatic model_edge();
    bit was [3];
    bit claimed [3];
    for (int t = 0; t < 3; t++) claimed[t] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      was[i] = m_act[i];
      m_exp[i] = '0;
      if (was[i]) begin
        if (m_dec[i]) begin
          m_exp[i] = {1'b1, m_ok[i], m_pt[i], m_word[i]};
          m_act[i] = 1'b0;
        end else if (pt_a[m_thr[i]][PT_W-1] && !claimed[m_thr[i]]) begin
          claimed[m_thr[i]] = 1'b1;
          m_dec[i] = 1'b1; m_ok[i] = 1'b1; m_pt[i] = pt_a[m_thr[i]];
        end else if (now - m_start[i] == TMO) begin
          m_dec[i] = 1'b1; m_ok[i] = 1'b0; m_pt[i] = '0;
          if (m_tmo < 65535) m_tmo++;
        end
        if (slc_a[i][SLC_W-1] && m_drop < 65535) m_drop++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (!was[i] && slc_a[i][SLC_W-1]) begin
        m_act[i] = 1'b1; m_start[i] = now; m_word[i] = slc_a[i];
        m_thr[i] = int'(slc_a[i][5:4]);
        m_dec[i] = (m_thr[i] >= 3); m_ok[i] = 1'b0; m_pt[i] = '0;
      end
    end
    now++;
  endtask

  task automatic tick();
    @(posedge clock);
    if (rst) model_reset(); else model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      slc_a[i] = '0; pt_a[i] = '0; slc_b[i] = '0; pt_b[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mtc_a[i] !== '0) begin
        errors++; $display("FAIL reset_mtc[%0d]: got %h want 0", i, mtc_a[i]);
      end
    end
    checks++;
    if (busy_a !== 3'b000 || drop_a !== 16'd0 || tmo_a !== 16'd0) begin
      errors++; $display("FAIL reset_state: busy=%b drop=%0d tmo=%0d want 0/0/0", busy_a, drop_a, tmo_a);
    end
  endtask

  task automatic test_match();
    logic [SLC_W-1:0] s; logic [PT_W-1:0] p;
    do_reset();
    s = mk_slc(1); p = mk_pt();
    slc_a[0] = s; tick(); slc_a[0] = '0;
    for (int k = 1; k <= 4; k++) begin
      tick(); checks++;
      if (mtc_a[0] !== '0 || busy_a[0] !== 1'b1) begin
        errors++; $display("FAIL match_wait edge %0d: mtc=%h busy=%b want 0/1", k, mtc_a[0], busy_a[0]);
      end
    end
    pt_a[1] = p; tick(); pt_a[1] = '0;
    checks++;
    if (mtc_a[0] !== '0) begin errors++; $display("FAIL match_early: got %h want 0", mtc_a[0]); end
    tick(); checks++;
    if (mtc_a[0] !== {1'b1, 1'b1, p, s}) begin
      errors++; $display("FAIL match_pkt: got %h want %h", mtc_a[0], {1'b1, 1'b1, p, s});
    end
    checks++;
    if (busy_a[0] !== 1'b0) begin errors++; $display("FAIL match_busy: got %b want 0", busy_a[0]); end
    tick(); checks++;
    if (mtc_a[0] !== '0) begin errors++; $display("FAIL match_one_cycle: got %h want 0", mtc_a[0]); end
  endtask

  task automatic test_timeout();
    logic [SLC_W-1:0] s;
    do_reset();
    s = mk_slc(2);
    slc_a[1] = s; tick(); slc_a[1] = '0;
    for (int k = 1; k <= TMO; k++) begin
      tick(); checks++;
      if (mtc_a[1] !== '0) begin errors++; $display("FAIL timeout_early edge %0d: got %h", k, mtc_a[1]); end
      if (k == TMO - 1) begin
        checks++;
        if (tmo_a !== 16'd0) begin errors++; $display("FAIL timeout_cnt_early: got %0d want 0", tmo_a); end
      end
    end
    tick(); checks++;
    if (mtc_a[1] !== {1'b1, 1'b0, {PT_W{1'b0}}, s}) begin
      errors++; $display("FAIL timeout_pkt: got %h want %h", mtc_a[1], {1'b1, 1'b0, {PT_W{1'b0}}, s});
    end
    checks++;
    if (tmo_a !== 16'd1) begin errors++; $display("FAIL timeout_cnt: got %0d want 1", tmo_a); end
  endtask

  task automatic test_arbitration();
    logic [SLC_W-1:0] s0, s2; logic [PT_W-1:0] p;
    do_reset();
    s0 = mk_slc(0); s2 = mk_slc(0); p = mk_pt();
    slc_a[0] = s0; slc_a[2] = s2; tick(); slc_a[0] = '0; slc_a[2] = '0;
    tick(); tick();
    pt_a[0] = p; tick(); pt_a[0] = '0;
    tick(); checks++;
    if (mtc_a[0] !== {1'b1, 1'b1, p, s0}) begin
      errors++; $display("FAIL arb_winner: got %h want %h", mtc_a[0], {1'b1, 1'b1, p, s0});
    end
    checks++;
    if (mtc_a[2] !== '0 || busy_a[2] !== 1'b1) begin
      errors++; $display("FAIL arb_loser_waits: mtc=%h busy=%b want 0/1", mtc_a[2], busy_a[2]);
    end
    for (int k = 5; k <= TMO; k++) begin
      tick(); checks++;
      if (mtc_a[2] !== '0) begin errors++; $display("FAIL arb_loser_early edge %0d: got %h", k, mtc_a[2]); end
    end
    tick(); checks++;
    if (mtc_a[2] !== {1'b1, 1'b0, {PT_W{1'b0}}, s2}) begin
      errors++; $display("FAIL arb_loser_timeout: got %h want %h", mtc_a[2], {1'b1, 1'b0, {PT_W{1'b0}}, s2});
    end
  endtask

  task automatic test_drop();
    logic [SLC_W-1:0] s; logic [PT_W-1:0] p;
    int npk;
    do_reset();
    s = mk_slc(1); p = mk_pt(); npk = 0;
    for (int k = 0; k <= 15; k++) begin
      slc_a[0] = (k == 0) ? s : ((k <= 3) ? mk_slc(1) : '0);
      pt_a[1] = (k == 10) ? p : '0;
      tick();
      if (mtc_a[0][MTC_W-1]) npk++;
      if (k == 11) begin
        checks++;
        if (mtc_a[0] !== {1'b1, 1'b1, p, s}) begin
          errors++; $display("FAIL drop_pkt: got %h want %h", mtc_a[0], {1'b1, 1'b1, p, s});
        end
      end
    end
    clear_inputs();
    checks++;
    if (npk != 1) begin errors++; $display("FAIL drop_npkt: got %0d want 1", npk); end
    checks++;
    if (drop_a !== 16'd3) begin errors++; $display("FAIL drop_cnt: got %0d want 3", drop_a); end
  endtask

  task automatic test_no_thread();
    logic [SLC_W-1:0] s;
    do_reset();
    s = mk_slc(3);
    slc_a[2] = s; tick(); slc_a[2] = '0;
    checks++;
    if (mtc_a[2] !== '0 || busy_a[2] !== 1'b1) begin
      errors++; $display("FAIL nothread_latch: mtc=%h busy=%b want 0/1", mtc_a[2], busy_a[2]);
    end
    tick(); checks++;
    if (mtc_a[2] !== {1'b1, 1'b0, {PT_W{1'b0}}, s} || busy_a[2] !== 1'b0) begin
      errors++; $display("FAIL nothread_pkt: got %h busy=%b want %h/0", mtc_a[2], busy_a[2], {1'b1, 1'b0, {PT_W{1'b0}}, s});
    end
  endtask

  task automatic test_reset_mid();
    int npk;
    do_reset();
    npk = 0;
    slc_a[0] = mk_slc(0); slc_a[1] = mk_slc(1); tick();
    slc_a[0] = mk_slc(2); slc_a[1] = '0; tick(); slc_a[0] = '0;
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (busy_a !== 3'b000 || drop_a !== 16'd0 || tmo_a !== 16'd0) begin
      errors++; $display("FAIL midreset_state: busy=%b drop=%0d tmo=%0d want 0/0/0", busy_a, drop_a, tmo_a);
    end
    pt_a[0] = mk_pt(); pt_a[1] = mk_pt(); slc_a[2] = mk_slc(3); tick(); clear_inputs();
    checks++;
    if (busy_a !== 3'b100) begin errors++; $display("FAIL first_after_reset busy: got %b want 100", busy_a); end
    for (int k = 0; k < 80; k++) begin
      tick();
      if (mtc_a[0][MTC_W-1] || mtc_a[1][MTC_W-1]) npk++;
    end
    checks++;
    if (npk != 0) begin errors++; $display("FAIL midreset_no_packet: got %0d packets want 0", npk); end
  endtask

  task automatic test_saturation();
    int exp_drop;
    do_reset();
    slc_b[0] = mk_slc(1);
    for (int k = 0; k <= 20; k++) begin
      tick();
      if (k == 10) begin
        checks++;
        if (drop_b !== 4'd10) begin errors++; $display("FAIL sat_partial: got %0d want 10", drop_b); end
      end
    end
    clear_inputs();
    exp_drop = (20 > 15) ? 15 : 20;
    checks++;
    if (drop_b !== 4'(exp_drop)) begin errors++; $display("FAIL sat_drop: got %0d want %0d", drop_b, exp_drop); end
  endtask

  task automatic test_random();
    logic [2:0] mbusy;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) begin
        slc_a[i] = ($urandom_range(0, 3) == 0) ? mk_slc($urandom_range(0, 3)) : SLC_W'($urandom) & {1'b0, {(SLC_W-1){1'b1}}};
        pt_a[i]  = ($urandom_range(0, 9) == 0) ? mk_pt() : '0;
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        mbusy[i] = m_act[i];
        checks++;
        if (mtc_a[i] !== m_exp[i]) begin
          errors++; $display("FAIL rand_mtc[%0d] cyc %0d: got %h want %h", i, n, mtc_a[i], m_exp[i]);
        end
      end
      checks++;
      if (busy_a !== mbusy || drop_a !== 16'(m_drop) || tmo_a !== 16'(m_tmo)) begin
        errors++; $display("FAIL rand_status cyc %0d: busy=%b drop=%0d tmo=%0d want %b/%0d/%0d",
                           n, busy_a, drop_a, tmo_a, mbusy, m_drop, m_tmo);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_match();
    test_timeout();
    test_arbitration();
    test_drop();
    test_no_thread();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtc_builder_sync.md
MTC_BUILDER_SYNC -- requirements
Module: mtc_builder_sync

Interface
REQ-001 Parameters SHALL be:
- PTCALC_WIDTH, default PTCALC2MTC_LEN: ptcalc word width; MSB = valid.
- SLC_WIDTH, default PL2MTC_LEN: slc word width; MSB = valid.
- PCH_MSB / PCH_LSB, defaults PL2MTC_PROCESS_CH_MSB / _LSB: process-channel field position in the slc word.
- N_THREADS, default 3: number of ptcalc threads.
- N_SL, default 3: number of slc slots and outputs.
- TIMEOUT, default 64: wait limit in cycles, 1..1023.
- CNT_WIDTH, default 16: width of the status counters.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1: the single clock.
- rst, in, 1: reset, synchronous, active-high.
- slc, in, [SLC_WIDTH-1:0] x N_SL: slc pipeline candidates.
- ptcalc, in, [PTCALC_WIDTH-1:0] x N_THREADS: pt results.
- mtc, out, [SLC_WIDTH+PTCALC_WIDTH+1:0] x N_SL: built packets.
- drop_cnt, out, CNT_WIDTH: overflow drop count.
- timeout_cnt, out, CNT_WIDTH: timeout count.
- busy, out, N_SL: per-slot not-IDLE flag.
REQ-003 mtc word layout SHALL be {valid, pt_ok, ptcalc payload, slc word}: valid at the MSB, pt_ok next below it.

Function
REQ-004 Each slot SHALL run its own FSM with states IDLE, WAIT and EMIT.
REQ-005 IDLE: when slc[i] valid=1, the slot SHALL latch the slc word, latch thread = PCH field, clear its wait counter, and go to WAIT; if PCH >= N_THREADS it SHALL go to EMIT with pt_ok=0 instead.
REQ-006 WAIT: the wait counter SHALL increment by one every cycle.
REQ-007 WAIT: when ptcalc[thread] valid=1 and this slot wins arbitration (REQ-010), the slot SHALL latch the ptcalc word and go to EMIT with pt_ok=1.
REQ-008 WAIT: when the counter equals TIMEOUT-1 and there is no match, the slot SHALL go to EMIT with pt_ok=0, ptcalc payload 0, and increment timeout_cnt.
REQ-009 A match and a timeout in the same cycle SHALL resolve as a match.
REQ-010 When several WAIT slots share one thread, a valid ptcalc word SHALL be consumed only by the lowest-index slot among them; the others keep waiting.
REQ-011 A ptcalc valid in the same cycle an slc is latched SHALL NOT match that slc; matching starts the cycle after latch.
REQ-012 EMIT: mtc[i] SHALL be registered with valid=1 for exactly one cycle, and the slot SHALL return to IDLE in that same cycle.
REQ-013 mtc[i] SHALL be all-zero in every cycle where no packet is emitted.
REQ-014 Latency: the match or timeout decision at cycle N SHALL give mtc[i] valid at N+1; a no-thread slc latched at N SHALL give mtc[i] valid at N+1.
REQ-015 An slc[i] valid arriving while slot i is in WAIT or EMIT SHALL be discarded and SHALL increment drop_cnt.
REQ-016 An slc[i] valid that arrives in the cycle its slot returns to IDLE SHALL be discarded.
REQ-017 drop_cnt and timeout_cnt SHALL saturate at all-ones and never wrap.
REQ-018 Several counter events in one cycle SHALL add their sum, clamped at saturation.
REQ-019 busy[i] SHALL be 1 whenever slot i is not in IDLE.
REQ-020 The ptcalc payload in mtc SHALL be the latched ptcalc word including its valid bit.
REQ-021 The slc field in mtc SHALL be the latched slc word.

Reset
REQ-022 While rst=1 at a clock edge, all slots SHALL go to IDLE and all wait counters SHALL clear.
REQ-023 Reset values: mtc = 0, drop_cnt = 0, timeout_cnt = 0, busy = 0.
REQ-024 A reset mid-WAIT or mid-EMIT SHALL abandon the pending entry with no packet and no counter increment.
REQ-025 The first slc accepted after reset SHALL be one sampled at the first edge with rst=0.

Verification
REQ-026 slc[0] valid with PCH=1 at cycle 0, ptcalc[1] valid at cycle 5 -> mtc[0] valid=1, pt_ok=1 at cycle 6, busy[0]=0 at cycle 6.
REQ-027 slc[1] valid with PCH=2, no ptcalc, TIMEOUT=64 -> mtc[1] valid=1, pt_ok=0, payload 0, timeout_cnt=1; nothing earlier.
REQ-028 slc[0] and slc[2] both PCH=0, one ptcalc[0] pulse -> slot 0 emits pt_ok=1; slot 2 later times out with pt_ok=0.
REQ-029 slc[0] valid for 4 consecutive cycles, ptcalc[PCH] valid 10 cycles after the first -> one packet, drop_cnt=3.
REQ-030 slc[2] valid with PCH=3 (N_THREADS=3) -> mtc[2] valid, pt_ok=0 one cycle later.
REQ-031 rst=1 pulse while slots 0 and 1 are in WAIT -> no packet ever emitted for them; busy=0 and counters=0 at the next cycle; CNT_WIDTH=4 with 20 drops -> drop_cnt=15.
